// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator: fetch handshake, commit-driven advance, target select
// Owns the architectural PC, retired-instruction counter and misaligned-target reporting.
module pc_gen #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] RESET_VEC = 32'h8000_0000,
   parameter int          IALIGN    = 4,
   parameter int          CNT_W     = 64
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ifu_req_valid,
   input  logic             ifu_req_ready,
   input  logic             commit_valid,
   input  logic             inst_is_c,
   input  logic             IsBr,
   input  logic             BrTaken,
   input  logic             IsJAL,
   input  logic             IsJALR,
   input  logic [XLEN-1:0]  alu_result,
   input  logic             trap_valid,
   input  logic [XLEN-1:0]  trap_vec,
   input  logic             mret_valid,
   input  logic [XLEN-1:0]  mepc,
   output logic [XLEN-1:0]  pc_current,
   output logic [XLEN-1:0]  pc_snpc,
   output logic [XLEN-1:0]  next_pc,
   output logic             misalign_valid,
   output logic [XLEN-1:0]  misalign_addr,
   output logic [CNT_W-1:0] instret
);

   localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_VEC);

   typedef enum logic [1:0] {BOOT, FETCH, WAIT} state_t;
   state_t state;

   logic            jump_sel;
   logic            jump_mis;
   logic            misalign;
   logic [XLEN-1:0] jump_tgt;

   always_comb begin
      pc_snpc  = pc_current + ((IALIGN == 2 && inst_is_c) ? XLEN'(2) : XLEN'(4));
      jump_sel = IsJALR | IsJAL | (IsBr & BrTaken);
      jump_tgt = IsJALR ? {alu_result[XLEN-1:1], 1'b0} : alu_result;
      jump_mis = (IALIGN == 2) ? jump_tgt[0] : (jump_tgt[1:0] != 2'b00);
      // Only a jump/branch target is checked; trap and mret targets are trusted.
      misalign = !trap_valid && !mret_valid && jump_sel && jump_mis;
      if (trap_valid)
         next_pc = trap_vec;
      else if (mret_valid)
         next_pc = mepc;
      else if (jump_sel)
         next_pc = misalign ? trap_vec : jump_tgt;
      else
         next_pc = pc_snpc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= BOOT;
         pc_current     <= RST_PC;
         ifu_req_valid  <= 1'b0;
         misalign_valid <= 1'b0;
         misalign_addr  <= '0;
         instret        <= '0;
      end else begin
         misalign_valid <= 1'b0;
         case (state)
            BOOT: begin
               state         <= FETCH;
               ifu_req_valid <= 1'b1;
            end
            FETCH: begin
               if (ifu_req_ready) begin
                  state         <= WAIT;
                  ifu_req_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (commit_valid) begin
                  state          <= FETCH;
                  ifu_req_valid  <= 1'b1;
                  pc_current     <= next_pc;
                  instret        <= instret + CNT_W'(1);
                  misalign_valid <= misalign;
                  if (misalign)
                     misalign_addr <= jump_tgt;
               end
            end
            default: begin
               state         <= BOOT;
               ifu_req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized self-checking bench for pc_gen, IALIGN=4 and IALIGN=2 side by side
module tb_pc_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ifu_req_ready = 1'b0, commit_valid = 1'b0, inst_is_c = 1'b0;
   logic is_br = 1'b0, br_taken = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
   logic trap_valid = 1'b0, mret_valid = 1'b0;
   logic [31:0] alu_result = '0, trap_vec = '0, mepc = '0;

   logic [1:0]       req_valid, mis_valid;
   logic [1:0][31:0] pc_cur, snpc, npc, mis_addr;
   logic [1:0][63:0] ret_cnt;

   always #5 clk = ~clk;

   pc_gen #(.IALIGN(4)) dut4 (
      .clk(clk), .rst(rst), .ifu_req_valid(req_valid[0]), .ifu_req_ready(ifu_req_ready),
      .commit_valid(commit_valid), .inst_is_c(inst_is_c), .IsBr(is_br), .BrTaken(br_taken),
      .IsJAL(is_jal), .IsJALR(is_jalr), .alu_result(alu_result), .trap_valid(trap_valid),
      .trap_vec(trap_vec), .mret_valid(mret_valid), .mepc(mepc), .pc_current(pc_cur[0]),
      .pc_snpc(snpc[0]), .next_pc(npc[0]), .misalign_valid(mis_valid[0]),
      .misalign_addr(mis_addr[0]), .instret(ret_cnt[0]));

   pc_gen #(.IALIGN(2)) dut2 (
      .clk(clk), .rst(rst), .ifu_req_valid(req_valid[1]), .ifu_req_ready(ifu_req_ready),
      .commit_valid(commit_valid), .inst_is_c(inst_is_c), .IsBr(is_br), .BrTaken(br_taken),
      .IsJAL(is_jal), .IsJALR(is_jalr), .alu_result(alu_result), .trap_valid(trap_valid),
      .trap_vec(trap_vec), .mret_valid(mret_valid), .mepc(mepc), .pc_current(pc_cur[1]),
      .pc_snpc(snpc[1]), .next_pc(npc[1]), .misalign_valid(mis_valid[1]),
      .misalign_addr(mis_addr[1]), .instret(ret_cnt[1]));

   int errs = 0;
   int checks = 0;
   int ialign [2] = '{4, 2};

   logic [31:0] m_pc [2];
   logic [63:0] m_ret [2];
   logic        m_mv [2];
   logic [31:0] m_ma [2];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_snpc(input int k);
      return m_pc[k] + ((ialign[k] == 2 && inst_is_c) ? 32'd2 : 32'd4);
   endfunction

   // Architectural next PC from the current control inputs.
   function automatic logic [31:0] m_next(input int k, output logic mis, output logic [31:0] tgt);
      mis = 1'b0;
      tgt = is_jalr ? (alu_result & ~32'd1) : alu_result;
      if (trap_valid) return trap_vec;
      if (mret_valid) return mepc;
      if (is_jalr || is_jal || (is_br && br_taken)) begin
         mis = (ialign[k] == 4) ? (tgt % 4 != 0) : (tgt % 2 != 0);
         return mis ? trap_vec : tgt;
      end
      return m_snpc(k);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = 32'h8000_0000; m_ret[k] = '0; m_mv[k] = 1'b0; m_ma[k] = '0;
      end
   endtask

   task automatic check_state(input string tag);
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("%s_pc%0d", tag, ialign[k]), pc_cur[k], m_pc[k]);
         check_val($sformatf("%s_instret%0d", tag, ialign[k]), ret_cnt[k], m_ret[k]);
         check_val($sformatf("%s_misv%0d", tag, ialign[k]), mis_valid[k], m_mv[k]);
         check_val($sformatf("%s_misa%0d", tag, ialign[k]), mis_addr[k], m_ma[k]);
      end
   endtask

   // Called at a negedge while reset can strike in any state.
   task automatic apply_reset(input string tag);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check_state({tag, "_rst"});
      for (int k = 0; k < 2; k++)
         check_val($sformatf("%s_rstvalid%0d", tag, ialign[k]), req_valid[k], 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         check_val($sformatf("%s_boot%0d", tag, ialign[k]), req_valid[k], 1'b0);
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         check_val($sformatf("%s_first%0d", tag, ialign[k]), req_valid[k], 1'b1);
   endtask

   // Entered at a negedge in FETCH; leaves at the negedge after the commit edge.
   task automatic run_inst(input string tag, input int rdy_delay, input int cmt_delay,
                           input logic spur, input logic c, input logic br, input logic tk,
                           input logic jal, input logic jalr, input logic [31:0] alu,
                           input logic trap, input logic [31:0] tv,
                           input logic mret, input logic [31:0] ep);
      logic        mis;
      logic [31:0] tgt, exp_npc;
      inst_is_c = c; is_br = br; br_taken = tk; is_jal = jal; is_jalr = jalr;
      alu_result = alu; trap_valid = trap; trap_vec = tv; mret_valid = mret; mepc = ep;
      for (int i = 0; i <= rdy_delay; i++) begin
         for (int k = 0; k < 2; k++) begin
            check_val($sformatf("%s_fvalid%0d", tag, ialign[k]), req_valid[k], 1'b1);
            check_val($sformatf("%s_fpc%0d", tag, ialign[k]), pc_cur[k], m_pc[k]);
            check_val($sformatf("%s_fret%0d", tag, ialign[k]), ret_cnt[k], m_ret[k]);
         end
         ifu_req_ready = (i == rdy_delay);
         commit_valid = spur;
         @(negedge clk);
      end
      ifu_req_ready = 1'b0;
      for (int i = 0; i <= cmt_delay; i++) begin
         for (int k = 0; k < 2; k++) begin
            check_val($sformatf("%s_wvalid%0d", tag, ialign[k]), req_valid[k], 1'b0);
            check_val($sformatf("%s_wpc%0d", tag, ialign[k]), pc_cur[k], m_pc[k]);
            check_val($sformatf("%s_wmisv%0d", tag, ialign[k]), mis_valid[k], 1'b0);
            check_val($sformatf("%s_snpc%0d", tag, ialign[k]), snpc[k], m_snpc(k));
            exp_npc = m_next(k, mis, tgt);
            check_val($sformatf("%s_npc%0d", tag, ialign[k]), npc[k], exp_npc);
         end
         commit_valid = (i == cmt_delay);
         ifu_req_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      commit_valid = 1'b0;
      ifu_req_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = m_next(k, mis, tgt);
         m_ret[k] = m_ret[k] + 64'd1;
         m_mv[k] = mis;
         if (mis) m_ma[k] = tgt;
      end
      check_state(tag);
      for (int k = 0; k < 2; k++) m_mv[k] = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      model_reset();
      @(negedge clk);
      apply_reset("init");

      run_inst("seq_bp", 3, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h8000_0800, 0, 32'h0);
      run_inst("jal", 0, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0100, 0, 32'h8000_0800, 0, 32'h0);
      run_inst("br_nt", 0, 1, 0, 0, 1, 0, 0, 0, 32'h8000_0400, 0, 32'h8000_0800, 0, 32'h0);
      run_inst("jalr", 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0203, 0, 32'h8000_0800, 0, 32'h0);
      run_inst("prio", 1, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0102, 1, 32'h8000_1000, 1, 32'h8000_0040);
      run_inst("spur", 3, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h8000_0800, 0, 32'h0);

      // Reset while an instruction is outstanding.
      ifu_req_ready = 1'b1;
      @(negedge clk);
      ifu_req_ready = 1'b0;
      apply_reset("midwait");

      run_inst("cmp", 0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h8000_0800, 0, 32'h0);
      run_inst("to_top", 0, 0, 0, 0, 1, 1, 0, 0, 32'hFFFF_FFFC, 0, 32'h8000_0800, 0, 32'h0);
      run_inst("wrap", 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0, 32'h8000_0800, 0, 32'h0);

      for (int n = 0; n < 300; n++) begin
         r = $urandom;
         run_inst($sformatf("rnd%0d", n), $urandom_range(0, 3), $urandom_range(0, 2),
                  r[0], r[1], r[2], r[3], r[4] & r[5], r[6] & r[7],
                  $urandom, r[8] & r[9] & r[10], $urandom & ~32'd3,
                  r[11] & r[12] & r[13], $urandom);
         if (n == 150) apply_reset("rndrst");
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the multi-cycle NPC core, replacing the single-width, always-advancing PC register. It owns the architectural PC, issues fetch requests to the IFU over a valid/ready handshake, and advances only when the current instruction commits. It selects among trap, mret, jump, branch and sequential targets, detects misaligned targets, and keeps a retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32: PC and target width.
- `RESET_VEC`, 32'h8000_0000: PC value after reset (zero-extended/truncated to `XLEN`).
- `IALIGN`, 4: instruction alignment in bytes; legal values 4 or 2 (2 enables compressed lengths).
- `CNT_W`, 64: width of retired-instruction counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ifu_req_valid` output 1: fetch request for `pc_current`.
- `ifu_req_ready` input 1: IFU accepts request.
- `commit_valid` input 1: current instruction finished; PC may advance.
- `inst_is_c` input 1: current instruction is 16-bit; ignored when `IALIGN`==4.
- `IsBr`, `BrTaken`, `IsJAL`, `IsJALR` input 1 each: control-flow class of committing instruction.
- `alu_result` input XLEN: jump/branch target.
- `trap_valid` input 1: take trap at commit.
- `trap_vec` input XLEN: trap handler address (mtvec).
- `mret_valid` input 1: return from trap at commit.
- `mepc` input XLEN: return address.
- `pc_current` output XLEN: architectural PC.
- `pc_snpc` output XLEN: static next PC (`pc_current` + 4, or + 2 when `IALIGN`==2 and `inst_is_c`).
- `next_pc` output XLEN: combinational PC that will be loaded at commit (exported for difftest).
- `misalign_valid` output 1: one-cycle pulse, target misaligned.
- `misalign_addr` output XLEN: offending target, held until next pulse.
- `instret` output CNT_W: retired-instruction count.

## Operation
- States: BOOT, FETCH, WAIT.
  - BOOT: entered on reset; `ifu_req_valid`=0; unconditionally -> FETCH next cycle.
  - FETCH: `ifu_req_valid`=1; on `ifu_req_valid && ifu_req_ready` -> WAIT. `pc_current` stable.
  - WAIT: `ifu_req_valid`=0; on `commit_valid` load `pc_current <= next_pc`, `instret++`, -> FETCH.
- `commit_valid` in BOOT/FETCH is ignored (no PC change, no count).
- `next_pc` priority: `trap_valid` -> `trap_vec`; `mret_valid` -> `mepc`; `IsJALR` -> `alu_result` with bit0 cleared; `IsJAL` -> `alu_result`; `IsBr && BrTaken` -> `alu_result`; else `pc_snpc`.
- Misalignment check on selected jump/branch target only (not trap_vec/mepc/snpc): misaligned if `target[1:0]!=0` (`IALIGN`=4) or `target[0]!=0` (`IALIGN`=2). If misaligned: `next_pc`=`trap_vec`, `misalign_valid` pulses in the cycle after the commit edge, `misalign_addr` latches target; `instret` still increments.
- All adds wrap modulo 2^XLEN; `instret` wraps modulo 2^CNT_W.

## Timing
- Reset (async assert, any state): `pc_current`=`RESET_VEC`, state BOOT, `ifu_req_valid`=0, `misalign_valid`=0, `misalign_addr`=0, `instret`=0. Mid-handshake reset abandons the request.
- First `ifu_req_valid` high in second cycle after reset release.
- Handshake: `ifu_req_valid` stays high and `pc_current` constant until ready sampled high; ready while valid low has no effect.
- Commit edge updates `pc_current`; `ifu_req_valid` high from the following cycle. Minimum loop: 1 FETCH cycle (ready tied high) + 1 WAIT cycle = 2 cycles per instruction.
- `next_pc`, `pc_snpc` combinational from current inputs and `pc_current`.

## Test plan
- Reset/boot: assert `rst` mid-WAIT -> `pc_current`=0x8000_0000, `ifu_req_valid`=0 immediately, high 2 cycles after release; `instret`=0.
- Sequential with IFU backpressure: ready low 3 cycles then high, commit -> `ifu_req_valid` held 4 cycles, PC 0x8000_0000 -> 0x8000_0004, `instret`=1.
- Control flow: JAL target 0x8000_0100, then branch not-taken, then JALR target 0x8000_0203 -> PCs 0x8000_0100, 0x8000_0104, 0x8000_0202 (with `IALIGN`=2) / misalign pulse at 0x8000_0202 (`IALIGN`=4) redirecting to `trap_vec`.
- Priority: `trap_valid`, `IsJAL` and `mret_valid` all high at commit, `trap_vec`=0x8000_1000 -> PC 0x8000_1000, no misalign pulse.
- Compressed: `IALIGN`=2, `inst_is_c`=1 at PC 0x8000_0000 -> `pc_snpc`=0x8000_0002; wrap: PC 0xFFFF_FFFC sequential commit -> 0x0000_0000.
- Spurious commit: `commit_valid` high during FETCH -> PC and `instret` unchanged.
